// File: rtl/led_blink_driver_if.sv
// Request/status bundle between control logic and the LED blink driver.
interface led_blink_driver_if;
  logic       start;
  logic [3:0] blink_num;
  logic       led;
  logic       busy;
  logic       done;

  modport master (output start, output blink_num, input led, input busy, input done);
  modport slave  (input start, input blink_num, output led, output busy, output done);
endinterface

// File: rtl/led_blink_driver.sv
// Turns a start pulse into N LED blinks of ON_TICKS on / OFF_TICKS off, then pulses done.
// Optional LED_BLINK_RETRIGGER_EN: a start while busy restarts the sequence.
module led_blink_driver #(
  parameter int unsigned CNT_W     = 20,
  parameter int unsigned ON_TICKS  = 20'hFFFF,
  parameter int unsigned OFF_TICKS = 20'hFFFF
) (
  input  logic               clk,
  input  logic               rst,
  led_blink_driver_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_TICKS - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] tick_reg, tick_next;
  logic [3:0]       remain_reg, remain_next;
  logic             done_reg, done_next;
  logic             accept;

  assign accept = bus.start && (bus.blink_num != 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      tick_reg   <= '0;
      remain_reg <= 4'd0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      tick_reg   <= tick_next;
      remain_reg <= remain_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    tick_next   = tick_reg;
    remain_next = remain_reg;
    done_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next  = ON;
          tick_next   = '0;
          remain_next = bus.blink_num;
        end
      end
      ON: begin
        if (tick_reg == ON_LAST) begin
          state_next = OFF;
          tick_next  = '0;
        end else begin
          tick_next = tick_reg + CNT_W'(1);
        end
      end
      OFF: begin
        if (tick_reg == OFF_LAST) begin
          tick_next = '0;
          if (remain_reg > 4'd1) begin
            remain_next = remain_reg - 4'd1;
            state_next  = ON;
          end else begin
            // Sequence ends on this edge; a start here chains with no idle cycle.
            done_next = 1'b1;
            if (accept) begin
              state_next  = ON;
              remain_next = bus.blink_num;
            end else begin
              state_next  = IDLE;
              remain_next = 4'd0;
            end
          end
        end else begin
          tick_next = tick_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next  = IDLE;
        tick_next   = '0;
        remain_next = 4'd0;
      end
    endcase
`ifdef LED_BLINK_RETRIGGER_EN
    // Restart overrides normal sequencing; done only survives if the old sequence ended here.
    if ((state_reg != IDLE) && accept) begin
      state_next  = ON;
      tick_next   = '0;
      remain_next = bus.blink_num;
    end
`endif
  end

  assign bus.led  = (state_reg == ON);
  assign bus.busy = (state_reg != IDLE);
  assign bus.done = done_reg;

endmodule
